// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if
// Bundles the three buses around the cache controller:
//   - the CPU request/response port,
//   - the next-level memory port,
//   - the control/victim signals exchanged with the lru replacement block.
// Modports:
//   slave  - the controller's view. CPU and memory inputs come in; the
//            response, memory request and lru controls go out.
//   master - the environment's view (CPU, memory and lru), the reverse.
// Parameters must match the cache_ctrl instance that uses this bus.
interface cache_ctrl_if #(
  parameter int INDEX_SIZE    = 4,
  parameter int ASSOCIATIVITY = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
);
  localparam int NUM_INDICES = $clog2(INDEX_SIZE);
  localparam int COUNT_SIZE  = $clog2(ASSOCIATIVITY);

  // CPU side
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   resp_valid;
  logic [DATA_WIDTH-1:0]  resp_rdata;
  logic                   resp_hit;

  // memory side
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   mem_resp_valid;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  // lru side
  logic [NUM_INDICES-1:0] lru_index;
  logic [COUNT_SIZE-1:0]  lru_asso_index;
  logic [COUNT_SIZE-1:0]  lru_select;
  logic                   lru_read_trigger;
  logic                   lru_write_trigger;
  logic                   lru_reset;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output lru_index, lru_asso_index, lru_read_trigger, lru_write_trigger, lru_reset,
    input  lru_select
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  lru_index, lru_asso_index, lru_read_trigger, lru_write_trigger, lru_reset,
    output lru_select
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl
// Set-associative cache controller with one word per line. Read misses
// allocate a line; writes are write-through and never allocate. The
// controller drives the external lru block: it announces the active set,
// pulses a read trigger when a way is touched on a hit and a write trigger
// when a way is filled, and consumes lru_select as the victim when every
// way of the set is valid.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - cache_ctrl_if.slave: CPU request/response, memory request/
//            response, lru controls (lru_reset = ~reset, combinational)
// All bus outputs except lru_reset are registered. One request in flight.
module cache_ctrl #(
  parameter int INDEX_SIZE    = 4,
  parameter int ASSOCIATIVITY = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic          clk,
  input  logic          reset,
  cache_ctrl_if.slave   bus
);
  localparam int NUM_INDICES = $clog2(INDEX_SIZE);
  localparam int COUNT_SIZE  = $clog2(ASSOCIATIVITY);
  localparam int TAG_W       = ADDR_WIDTH - NUM_INDICES;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    WT_REQ,
    RESP
  } state_t;

  state_t state;

  logic                   cap_write;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic [DATA_WIDTH-1:0]  cap_wdata;
  logic                   hit_reg;
  logic [COUNT_SIZE-1:0]  victim;

  logic [TAG_W-1:0]         tag_array   [INDEX_SIZE][ASSOCIATIVITY];
  logic [DATA_WIDTH-1:0]    data_array  [INDEX_SIZE][ASSOCIATIVITY];
  logic [ASSOCIATIVITY-1:0] valid_array [INDEX_SIZE];

  logic [NUM_INDICES-1:0] cap_index;
  logic [TAG_W-1:0]       cap_tag;
  logic                   hit_any;
  logic [COUNT_SIZE-1:0]  hit_way;
  logic                   inv_any;
  logic [COUNT_SIZE-1:0]  inv_way;

  assign cap_index     = cap_addr[NUM_INDICES-1:0];
  assign cap_tag       = cap_addr[ADDR_WIDTH-1:NUM_INDICES];
  assign bus.lru_reset = ~reset;

  // Tag match and free-way search for the captured set. Scanning from the
  // highest way down lets the lowest-numbered invalid way win.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (valid_array[cap_index][w] && (tag_array[cap_index][w] == cap_tag)) begin
        hit_any = 1'b1;
        hit_way = COUNT_SIZE'(w);
      end
      if (!valid_array[cap_index][w]) begin
        inv_any = 1'b1;
        inv_way = COUNT_SIZE'(w);
      end
    end
  end

  // Tag and data storage are deliberately left out of reset; only the valid
  // bits decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (reset && (state == LOOKUP) && cap_write && hit_any) begin
      data_array[cap_index][hit_way] <= cap_wdata;
    end
    if (reset && (state == MISS_WAIT) && bus.mem_resp_valid) begin
      tag_array[cap_index][victim]  <= cap_tag;
      data_array[cap_index][victim] <= bus.mem_rdata;
    end
  end

  // Controller state machine with registered outputs. Trigger and response
  // pulses default low every cycle so each is high for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      cap_write             <= 1'b0;
      cap_addr              <= '0;
      cap_wdata             <= '0;
      hit_reg               <= 1'b0;
      victim                <= '0;
      for (int i = 0; i < INDEX_SIZE; i++) begin
        valid_array[i] <= '0;
      end
      bus.req_ready         <= 1'b1;
      bus.resp_valid        <= 1'b0;
      bus.resp_rdata        <= '0;
      bus.resp_hit          <= 1'b0;
      bus.mem_req_valid     <= 1'b0;
      bus.mem_we            <= 1'b0;
      bus.mem_addr          <= '0;
      bus.mem_wdata         <= '0;
      bus.lru_index         <= '0;
      bus.lru_asso_index    <= '0;
      bus.lru_read_trigger  <= 1'b0;
      bus.lru_write_trigger <= 1'b0;
    end else begin
      bus.resp_valid        <= 1'b0;
      bus.lru_read_trigger  <= 1'b0;
      bus.lru_write_trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write     <= bus.req_write;
            cap_addr      <= bus.req_addr;
            cap_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            // Present the set to lru now so lru_select is meaningful in LOOKUP.
            bus.lru_index <= bus.req_addr[NUM_INDICES-1:0];
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_reg <= hit_any;
          if (hit_any) begin
            bus.lru_read_trigger <= 1'b1;
            bus.lru_asso_index   <= hit_way;
          end
          if (cap_write) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_we        <= 1'b1;
            bus.mem_addr      <= cap_addr;
            bus.mem_wdata     <= cap_wdata;
            state             <= WT_REQ;
          end else if (hit_any) begin
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= data_array[cap_index][hit_way];
            bus.resp_hit   <= 1'b1;
            state          <= RESP;
          end else begin
            victim            <= inv_any ? inv_way : bus.lru_select;
            bus.mem_req_valid <= 1'b1;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= cap_addr;
            state             <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          // A response arriving in the acceptance cycle is not looked at here.
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.mem_resp_valid) begin
            valid_array[cap_index][victim] <= 1'b1;
            bus.lru_write_trigger <= 1'b1;
            bus.lru_asso_index    <= victim;
            bus.resp_valid        <= 1'b1;
            bus.resp_rdata        <= bus.mem_rdata;
            bus.resp_hit          <= 1'b0;
            state                 <= RESP;
          end
        end
        WT_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.resp_valid    <= 1'b1;
            bus.resp_rdata    <= '0;
            bus.resp_hit      <= hit_reg;
            state             <= RESP;
          end
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
// Directed bench for cache_ctrl. Each request pushes its hand-computed
// response onto a scoreboard queue; a monitor pops and compares whenever
// resp_valid is seen. A behavioural memory (contents addr ^ 0xA0, updated
// by write-through) and a stub lru_select drive the DUT.
module tb_cache_ctrl;
  localparam int INDEX_SIZE    = 4;
  localparam int ASSOCIATIVITY = 4;
  localparam int ADDR_WIDTH    = 8;
  localparam int DATA_WIDTH    = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  cache_ctrl_if #(
    .INDEX_SIZE(INDEX_SIZE), .ASSOCIATIVITY(ASSOCIATIVITY),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  cache_ctrl #(
    .INDEX_SIZE(INDEX_SIZE), .ASSOCIATIVITY(ASSOCIATIVITY),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] rdata;
    logic       hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   resp_count = 0;
  int   wr_trig_count = 0;
  int   rd_trig_count = 0;
  logic [1:0] last_wr_asso = '0;
  logic [1:0] last_rd_asso = '0;

  logic [7:0] mem_array [256];
  int         stall_left = 0;
  logic       suppress_resp = 1'b0;
  logic       resp_pending = 1'b0;
  logic [7:0] resp_data = '0;
  int         mem_req_count = 0;
  logic [7:0] last_mem_addr = '0;
  logic       last_mem_we = 1'b0;
  logic [7:0] last_mem_wdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory model: decides ready/response at each negedge for the next
  // posedge; a read is answered the cycle after it is accepted.
  initial begin
    for (int i = 0; i < 256; i++) mem_array[i] = 8'(i) ^ 8'hA0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (resp_pending && !suppress_resp) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = resp_data;
        resp_pending       = 1'b0;
      end
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
          mem_req_count++;
          last_mem_addr  = bus.mem_addr;
          last_mem_we    = bus.mem_we;
          last_mem_wdata = bus.mem_wdata;
          if (bus.mem_we) begin
            mem_array[bus.mem_addr] = bus.mem_wdata;
          end else begin
            resp_pending = 1'b1;
            resp_data    = mem_array[bus.mem_addr];
          end
        end
      end
    end
  end

  // Monitor: trigger bookkeeping and scoreboard comparison on resp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.lru_write_trigger) begin
        wr_trig_count++;
        last_wr_asso = bus.lru_asso_index;
      end
      if (bus.lru_read_trigger) begin
        rd_trig_count++;
        last_rd_asso = bus.lru_asso_index;
      end
      if (bus.resp_valid) begin
        resp_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
          checkOutput("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
        end
      end
    end
  end

  task automatic sendRequest(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    int n = 0;
    @(negedge clk); #2;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    checkOutput("req_ready_before_issue", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk); #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitResponse(input int start_count);
    int n = 0;
    while (resp_count == start_count && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    if (resp_count == start_count) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [7:0] exp_rdata, input logic exp_hit);
    int start;
    exp_q.push_back('{rdata: exp_rdata, hit: exp_hit});
    start = resp_count;
    sendRequest(wr, addr, wdata);
    waitResponse(start);
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("rst_lru_reset", 32'(bus.lru_reset), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("run_lru_reset", 32'(bus.lru_reset), 32'd0);
  endtask

  initial begin
    int rc;
    int mc;
    int n;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.lru_select = '0;

    doReset();
    checkOutput("rst_lru_trig", 32'({bus.lru_read_trigger, bus.lru_write_trigger}), 32'd0);

    // cold read miss fills way 0
    applyStimulus(1'b0, 8'h05, 8'h00, 8'hA5, 1'b0);
    checkOutput("miss_mem_addr", 32'(last_mem_addr), 32'h05);
    checkOutput("miss_mem_we", 32'(last_mem_we), 32'd0);
    checkOutput("miss_mem_count", mem_req_count, 1);
    checkOutput("fill_trig_count", wr_trig_count, 1);
    checkOutput("fill_asso", 32'(last_wr_asso), 32'd0);

    // re-read hits without memory traffic
    applyStimulus(1'b0, 8'h05, 8'h00, 8'hA5, 1'b1);
    checkOutput("hit_no_mem", mem_req_count, 1);
    checkOutput("hit_trig_count", rd_trig_count, 1);
    checkOutput("hit_asso", 32'(last_rd_asso), 32'd0);
    checkOutput("hit_lru_index", 32'(bus.lru_index), 32'd1);

    // fill all four ways of set 1, then replace the lru-selected way
    doReset();
    applyStimulus(1'b0, 8'h01, 8'h00, 8'hA1, 1'b0);
    checkOutput("fill_way0", 32'(last_wr_asso), 32'd0);
    applyStimulus(1'b0, 8'h05, 8'h00, 8'hA5, 1'b0);
    checkOutput("fill_way1", 32'(last_wr_asso), 32'd1);
    applyStimulus(1'b0, 8'h09, 8'h00, 8'hA9, 1'b0);
    checkOutput("fill_way2", 32'(last_wr_asso), 32'd2);
    applyStimulus(1'b0, 8'h0D, 8'h00, 8'hAD, 1'b0);
    checkOutput("fill_way3", 32'(last_wr_asso), 32'd3);
    bus.lru_select = 2'd2;
    applyStimulus(1'b0, 8'h11, 8'h00, 8'hB1, 1'b0);
    checkOutput("evict_way2", 32'(last_wr_asso), 32'd2);
    applyStimulus(1'b0, 8'h09, 8'h00, 8'hA9, 1'b0);
    checkOutput("evicted_refill_way", 32'(last_wr_asso), 32'd2);
    applyStimulus(1'b0, 8'h01, 8'h00, 8'hA1, 1'b1);
    checkOutput("survivor_hit_asso", 32'(last_rd_asso), 32'd0);

    // write hit: write-through plus cache update
    mc = mem_req_count;
    applyStimulus(1'b1, 8'h05, 8'h3C, 8'h00, 1'b1);
    checkOutput("wt_mem_we", 32'(last_mem_we), 32'd1);
    checkOutput("wt_mem_wdata", 32'(last_mem_wdata), 32'h3C);
    checkOutput("wt_mem_addr", 32'(last_mem_addr), 32'h05);
    checkOutput("wt_hit_asso", 32'(last_rd_asso), 32'd1);
    applyStimulus(1'b0, 8'h05, 8'h00, 8'h3C, 1'b1);
    checkOutput("updated_hit_no_mem", mem_req_count, mc + 1);

    // write miss does not allocate
    applyStimulus(1'b1, 8'h22, 8'h77, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h22, 8'h00, 8'h77, 1'b0);
    checkOutput("no_alloc_fill_way0", 32'(last_wr_asso), 32'd0);

    // memory stalls the miss request for 5 cycles
    stall_left = 5;
    exp_q.push_back('{rdata: 8'h90, hit: 1'b0});
    rc = resp_count;
    sendRequest(1'b0, 8'h30, 8'h00);
    n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    repeat (5) begin
      checkOutput("stall_req_valid", 32'(bus.mem_req_valid), 32'd1);
      checkOutput("stall_addr", 32'(bus.mem_addr), 32'h30);
      checkOutput("stall_no_early_resp", resp_count, rc);
      @(negedge clk); #2;
    end
    waitResponse(rc);

    // reset while waiting for memory abandons the request
    suppress_resp = 1'b1;
    rc = resp_count;
    mc = mem_req_count;
    sendRequest(1'b0, 8'h06, 8'h00);
    n = 0;
    while (mem_req_count == mc && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    checkOutput("abandon_req_issued", mem_req_count, mc + 1);
    @(negedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #2;
    checkOutput("abandon_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("abandon_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    reset = 1'b1;
    suppress_resp = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    checkOutput("abandon_no_resp", resp_count, rc);
    mc = mem_req_count;
    applyStimulus(1'b0, 8'h06, 8'h00, 8'hA6, 1'b0);
    applyStimulus(1'b0, 8'h05, 8'h00, 8'h3C, 1'b0);
    checkOutput("after_reset_misses", mem_req_count, mc + 2);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
